// File: rtl/alu_pkg.sv
// Shared definitions for the sequential board ALU: opcodes, FSM states
// and the bit positions of the status flags.
package alu_pkg;

    // Opcodes, 6 bits wide. Narrower builds keep only the low NB_OP bits.
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // FSM states. The encoding is visible on the status LEDs, so it is fixed.
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    // Flag bit positions within the {N,V,C,Z} flag word.
    localparam int NB_FLAGS = 4;
    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 2;
    localparam int FLAG_N   = 3;

endpackage

// File: rtl/alu_btn_edge.sv
// Rising-edge detector for one debounced button. The pulse is registered so
// the FSM sees a clean one-cycle strobe; a held button yields exactly one.
module alu_btn_edge
    import alu_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic btn_q_reg;
    logic pulse_reg;

    // Track the previous button level and register the 0->1 transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_q_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            btn_q_reg <= i_btn;
            pulse_reg <= i_btn & ~btn_q_reg;
        end
    end

    assign o_pulse = pulse_reg;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential board ALU. Operand A, operand B and the opcode are captured
// from one switch bank, one load press per field; the result and flags are
// then registered and held on the LEDs until the next execution or a clear.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NB_DATA-1:0]  i_sw,
    input  logic                i_btn_load,
    input  logic                i_btn_clear,
    output logic [NB_DATA-1:0]  o_led,
    output logic [NB_FLAGS-1:0] o_flags,
    output logic                o_valid,
    output logic                o_err,
    output logic [1:0]          o_state
);

    localparam int NB_SHAMT = $clog2(NB_DATA);
    localparam int MSB      = NB_DATA - 1;

    // Shift amounts at or above the data width saturate.
    localparam logic [NB_DATA-1:0] DATA_W = NB_DATA'(NB_DATA);

    // Opcodes trimmed to the configured opcode width.
    localparam logic [NB_OP-1:0] C_ADD = OP_ADD[NB_OP-1:0];
    localparam logic [NB_OP-1:0] C_SUB = OP_SUB[NB_OP-1:0];
    localparam logic [NB_OP-1:0] C_AND = OP_AND[NB_OP-1:0];
    localparam logic [NB_OP-1:0] C_OR  = OP_OR[NB_OP-1:0];
    localparam logic [NB_OP-1:0] C_XOR = OP_XOR[NB_OP-1:0];
    localparam logic [NB_OP-1:0] C_NOR = OP_NOR[NB_OP-1:0];
    localparam logic [NB_OP-1:0] C_SRA = OP_SRA[NB_OP-1:0];
    localparam logic [NB_OP-1:0] C_SRL = OP_SRL[NB_OP-1:0];

    logic load_p;
    logic clear_p;

    state_t                state_reg;
    logic [NB_DATA-1:0]    a_reg;
    logic [NB_DATA-1:0]    b_reg;
    logic [NB_OP-1:0]      op_reg;
    logic [NB_DATA-1:0]    led_reg;
    logic [NB_FLAGS-1:0]   flags_reg;
    logic                  valid_reg;
    logic                  err_reg;

    logic [NB_DATA-1:0]    res_next;
    logic [NB_FLAGS-1:0]   flags_next;
    logic                  err_next;

    logic [NB_DATA:0]      wide_sum;
    logic [NB_DATA:0]      wide_diff;
    logic [NB_SHAMT-1:0]   shamt;
    logic                  shift_big;
    logic signed [NB_DATA-1:0] a_signed;
    logic signed [NB_DATA-1:0] sra_res;
    logic [NB_DATA-1:0]    srl_res;

    alu_btn_edge u_load_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_load),
        .o_pulse (load_p)
    );

    alu_btn_edge u_clear_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_clear),
        .o_pulse (clear_p)
    );

    // One extra bit on add/subtract exposes carry-out and borrow directly.
    assign wide_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    assign wide_diff = {1'b0, a_reg} - {1'b0, b_reg};

    // Shifts use the full B value; only in-range amounts reach the shifter.
    assign shamt     = b_reg[NB_SHAMT-1:0];
    assign shift_big = (b_reg >= DATA_W);
    assign a_signed  = a_reg;
    assign sra_res   = a_signed >>> shamt;
    assign srl_res   = a_reg >> shamt;

    // ALU datapath: result, {N,V,C,Z} flags and invalid-opcode indication.
    always_comb begin
        res_next   = '0;
        flags_next = '0;
        err_next   = 1'b0;
        case (op_reg)
            C_ADD: begin
                res_next           = wide_sum[NB_DATA-1:0];
                flags_next[FLAG_C] = wide_sum[NB_DATA];
                flags_next[FLAG_V] = (a_reg[MSB] == b_reg[MSB]) &&
                                     (wide_sum[MSB] != a_reg[MSB]);
            end
            C_SUB: begin
                res_next           = wide_diff[NB_DATA-1:0];
                flags_next[FLAG_C] = wide_diff[NB_DATA];
                flags_next[FLAG_V] = (a_reg[MSB] != b_reg[MSB]) &&
                                     (wide_diff[MSB] != a_reg[MSB]);
            end
            C_AND: res_next = a_reg & b_reg;
            C_OR:  res_next = a_reg | b_reg;
            C_XOR: res_next = a_reg ^ b_reg;
            C_NOR: res_next = ~(a_reg | b_reg);
            C_SRL: res_next = shift_big ? '0 : srl_res;
            C_SRA: res_next = shift_big ? {NB_DATA{a_reg[MSB]}} : sra_res;
            default: err_next = 1'b1;
        endcase
        // Invalid opcodes report result 0 with every flag cleared, Z included.
        if (!err_next) begin
            flags_next[FLAG_Z] = (res_next == '0);
            flags_next[FLAG_N] = res_next[MSB];
        end
    end

    // Capture FSM: A, B, opcode, then a single execute cycle; clear wins over load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_A;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            led_reg   <= '0;
            flags_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else if (clear_p) begin
            state_reg <= S_A;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            led_reg   <= '0;
            flags_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_A: begin
                    if (load_p) begin
                        a_reg     <= i_sw;
                        valid_reg <= 1'b0;
                        state_reg <= S_B;
                    end
                end
                S_B: begin
                    if (load_p) begin
                        b_reg     <= i_sw;
                        state_reg <= S_OP;
                    end
                end
                S_OP: begin
                    if (load_p) begin
                        op_reg    <= i_sw[NB_OP-1:0];
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A load pulse arriving here is dropped, not queued.
                    led_reg   <= res_next;
                    flags_reg <= flags_next;
                    err_reg   <= err_next;
                    valid_reg <= 1'b1;
                    state_reg <= S_A;
                end
                default: state_reg <= S_A;
            endcase
        end
    end

    assign o_led   = led_reg;
    assign o_flags = flags_reg;
    assign o_valid = valid_reg;
    assign o_err   = err_reg;
    assign o_state = state_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl (NB_DATA=8, NB_OP=6): directed transactions with
// literal expectations plus a per-cycle comparison against a reference model.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       btn_load = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] led;
    logic [3:0] flags;
    logic       valid;
    logic       err;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sw        (sw),
        .i_btn_load  (btn_load),
        .i_btn_clear (btn_clear),
        .o_led       (led),
        .o_flags     (flags),
        .o_valid     (valid),
        .o_err       (err),
        .o_state     (state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU on plain integers. Returns err<<12 | {N,V,C,Z}<<8 | result.
    function automatic int ref_alu(input int a, input int b, input int op);
        int sa, sb, res, c, v, ok;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = 0; c = 0; v = 0; ok = 1;
        case (op)
            32: begin
                res = a + b;
                c = (res > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
                res = res % 256;
            end
            34: begin
                c = (a < b);
                v = (sa - sb > 127) || (sa - sb < -128);
                res = (a - b + 256) % 256;
            end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = 255 - (a | b);
            2:  res = (b >= 8) ? 0 : (a >> b);
            3:  res = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
            default: ok = 0;
        endcase
        if (ok == 0) return 1 << 12;
        return ((((res >= 128) ? 8 : 0) | (v ? 4 : 0) | (c ? 2 : 0) | ((res == 0) ? 1 : 0)) << 8) | res;
    endfunction

    // Reference sequencer: a button press is acted on at the edge after it is
    // first seen; fields fill in order A, B, opcode, then one execute cycle.
    int m_fld [3] = '{0, 0, 0};
    int m_phase = 0;
    int m_led = 0, m_flags = 0, m_valid = 0, m_err = 0;
    bit m_lprev = 0, m_cprev = 0, m_lact = 0, m_cact = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fld   <= '{0, 0, 0};
            m_phase <= 0;
            m_led   <= 0; m_flags <= 0; m_valid <= 0; m_err <= 0;
            m_lprev <= 0; m_cprev <= 0; m_lact <= 0; m_cact <= 0;
        end else begin
            m_lact  <= btn_load && !m_lprev;
            m_cact  <= btn_clear && !m_cprev;
            m_lprev <= btn_load;
            m_cprev <= btn_clear;
            if (m_cact) begin
                m_fld   <= '{0, 0, 0};
                m_phase <= 0;
                m_led   <= 0; m_flags <= 0; m_valid <= 0; m_err <= 0;
            end else if (m_phase == 3) begin
                m_led   <= ref_alu(m_fld[0], m_fld[1], m_fld[2]) & 255;
                m_flags <= (ref_alu(m_fld[0], m_fld[1], m_fld[2]) >> 8) & 15;
                m_err   <= (ref_alu(m_fld[0], m_fld[1], m_fld[2]) >> 12) & 1;
                m_valid <= 1;
                m_phase <= 0;
            end else if (m_lact) begin
                if (m_phase == 0) m_valid <= 0;
                m_fld[m_phase] <= (m_phase == 2) ? (int'(sw) & 63) : int'(sw);
                m_phase <= m_phase + 1;
            end
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        check("cyc_led",   int'(led),   m_led);
        check("cyc_flags", int'(flags), m_flags);
        check("cyc_valid", int'(valid), m_valid);
        check("cyc_err",   int'(err),   m_err);
        check("cyc_state", int'(state), m_phase);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [7:0] val);
        sw = val;
        btn_load = 1'b1;
        tick();
        btn_load = 1'b0;
        tick();
    endtask

    task automatic run_txn(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op_sw, input int exp_led,
                           input int exp_flags, input int exp_err);
        press(a);
        press(b);
        sw = op_sw;
        btn_load = 1'b1;
        tick();                         // edge that samples the op press
        btn_load = 1'b0;
        tick();                         // opcode captured, executing next
        check({name, "_state_exec"}, int'(state), 3);
        check({name, "_valid_early"}, int'(valid), 0);
        tick();                         // result registered
        check({name, "_led"},   int'(led),   exp_led);
        check({name, "_flags"}, int'(flags), exp_flags);
        check({name, "_valid"}, int'(valid), 1);
        check({name, "_err"},   int'(err),   exp_err);
        check({name, "_state"}, int'(state), 0);
        $display("txn %s a=0x%02h b=0x%02h op=0x%02h -> led=0x%02h flags=%04b err=%0b",
                 name, a, b, op_sw, led, flags, err);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_led",   int'(led),   0);
        check("rst_flags", int'(flags), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_err",   int'(err),   0);
        check("rst_state", int'(state), 0);
        rst_n = 1'b1;
        tick();

        // Arithmetic, shifts and logic ops
        run_txn("add_ovf",   8'h7F, 8'h01, 8'h20, 8'h80, 4'b1100, 0);
        run_txn("add_carry", 8'hFF, 8'h01, 8'h20, 8'h00, 4'b0011, 0);
        run_txn("sub_borrow",8'h05, 8'h07, 8'h22, 8'hFE, 4'b1010, 0);
        run_txn("sub_ovf",   8'h80, 8'h01, 8'h22, 8'h7F, 4'b0100, 0);
        run_txn("sra3",      8'h80, 8'h03, 8'h03, 8'hF0, 4'b1000, 0);
        run_txn("srl9",      8'h80, 8'h09, 8'h02, 8'h00, 4'b0001, 0);
        run_txn("sra9",      8'h80, 8'h09, 8'h03, 8'hFF, 4'b1000, 0);
        run_txn("srl7",      8'h80, 8'h07, 8'h02, 8'h01, 4'b0000, 0);
        run_txn("srl8",      8'h80, 8'h08, 8'h02, 8'h00, 4'b0001, 0);
        run_txn("sra8",      8'h80, 8'h08, 8'h03, 8'hFF, 4'b1000, 0);
        run_txn("and",       8'hF0, 8'h3C, 8'h24, 8'h30, 4'b0000, 0);
        run_txn("or",        8'hF0, 8'h3C, 8'h25, 8'hFC, 4'b1000, 0);
        run_txn("xor",       8'hF0, 8'h3C, 8'h26, 8'hCC, 4'b1000, 0);
        run_txn("nor",       8'hF0, 8'h3C, 8'h27, 8'h03, 4'b0000, 0);
        run_txn("add_hisw",  8'h03, 8'h02, 8'hE0, 8'h05, 4'b0000, 0);

        // Invalid opcode, then recovery
        run_txn("invalid",   8'h12, 8'h34, 8'h3F, 8'h00, 4'b0000, 1);
        run_txn("add_after", 8'h01, 8'h01, 8'h20, 8'h02, 4'b0000, 0);

        // Load held for 20 cycles in S_A captures A only
        sw = 8'h03;
        btn_load = 1'b1;
        repeat (20) tick();
        check("hold_state", int'(state), 1);
        check("hold_valid", int'(valid), 0);
        btn_load = 1'b0;
        tick();
        check("hold_state_rel", int'(state), 1);
        press(8'h04);
        // Opcode load held through the execute cycle and beyond
        sw = 8'h20;
        btn_load = 1'b1;
        tick();
        tick();
        check("exec_hold_state", int'(state), 3);
        tick();
        check("exec_hold_led",   int'(led),   8'h07);
        check("exec_hold_state0", int'(state), 0);
        repeat (5) tick();
        check("exec_hold_idle",  int'(state), 0);
        check("exec_hold_valid", int'(valid), 1);
        btn_load = 1'b0;
        tick();
        $display("txn held_load a=0x03 b=0x04 op=0x20 -> led=0x%02h state=%0d", led, state);

        // Clear together with load in S_B
        press(8'h55);
        check("clr_pre_state", int'(state), 1);
        btn_load = 1'b1;
        btn_clear = 1'b1;
        tick();
        btn_load = 1'b0;
        btn_clear = 1'b0;
        tick();
        check("clr_led",   int'(led),   0);
        check("clr_flags", int'(flags), 0);
        check("clr_valid", int'(valid), 0);
        check("clr_err",   int'(err),   0);
        check("clr_state", int'(state), 0);
        $display("txn clear_in_sb -> led=0x%02h state=%0d", led, state);
        run_txn("after_clr", 8'h10, 8'h20, 8'h20, 8'h30, 4'b0000, 0);

        // Asynchronous reset mid-sequence in S_OP
        press(8'h40);
        press(8'h41);
        check("arst_pre_state", int'(state), 2);
        rst_n = 1'b0;
        #1;
        check("arst_led",   int'(led),   0);
        check("arst_flags", int'(flags), 0);
        check("arst_valid", int'(valid), 0);
        check("arst_state", int'(state), 0);
        #1;
        rst_n = 1'b1;
        tick();
        $display("txn async_reset_in_sop -> led=0x%02h state=%0d", led, state);
        run_txn("after_arst", 8'h11, 8'h22, 8'h20, 8'h33, 4'b0000, 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
